// File: rtl/sd_blk_if.sv
// sd_blk_if: MiSTer SD block-level handshake between an initiator (floppy controller,
// HPS stand-in) and a block server.
//   sd_lba[4], sd_blk_cnt[4]  per-channel block address / block count minus 1
//   sd_rd, sd_wr              per-channel level requests, held until sd_ack
//   sd_ack                    one-hot, high for the whole transfer of the granted channel
//   sd_buff_addr/dout/wr      byte index, read data and write strobe into initiator buffer
//   sd_buff_din[4]            initiator buffer output, valid 1 cycle after sd_buff_addr
// Modports: master = initiator side, slave = server side.
interface sd_blk_if;
    logic [31:0] sd_lba      [4];
    logic [5:0]  sd_blk_cnt  [4];
    logic [3:0]  sd_rd;
    logic [3:0]  sd_wr;
    logic [3:0]  sd_ack;
    logic [13:0] sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din [4];
    logic        sd_buff_wr;

    modport master (
        output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/sd_blk_server.sv
// sd_blk_server: responder for the SD block interface. Arbitrates round-robin between four
// initiator channels and streams whole blocks between a byte-wide backing store and the
// granted initiator's sector buffer. Each drive owns one quarter of the store.
// Ports:
//   CLK, RESET_N          clock (posedge) and asynchronous active-low reset
//   sd                    sd_blk_if.slave handshake/buffer bus
//   img_blocks_i[4]       per-drive image size in blocks
//   img_wp_i              per-drive write protect
//   mem_addr_o/rd_o/wr_o  store address and request strobes, held until mem_ready_i
//   mem_wdata_o/rdata_i   store write/read data
//   mem_ready_i           access completes in the cycle this is high
//   err_o                 1-cycle pulse on an out-of-range (or write-protected) request
// Build option: define SD_BLK_SERVER_WP_EN to treat writes to write-protected drives as bad
// requests (bytes consumed and discarded, err_o pulsed, no store write).
module sd_blk_server #(
    parameter int unsigned BLKSZ  = 2,
    parameter int unsigned MEM_AW = 24
) (
    input  logic              CLK,
    input  logic              RESET_N,
    sd_blk_if.slave           sd,
    input  logic [23:0]       img_blocks_i [4],
    input  logic [3:0]        img_wp_i,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_o
);
    localparam int unsigned ShAmt    = BLKSZ + 7;
    localparam int unsigned OffW     = MEM_AW - 2;
    localparam logic [31:0] MaxBytes = 32'd16384;

    typedef enum logic [2:0] {
        StIdle, StGrant, StRdMem, StRdPut, StWrAddr, StWrGet, StWrMem, StDone
    } state_e;

    state_e            state_q;
    logic [3:0]        arm_q, arm_d;
    logic [1:0]        last_q, sel_q;
    logic              op_wr_q, bad_q;
    logic [31:0]       lba_q;
    logic [5:0]        cnt_q;
    logic [13:0]       idx_q, idx_nx, tot_last_q, tot_last_d;
    logic              bad_d, last_byte;
    logic [3:0]        ack_q;
    logic              buff_wr_q;
    logic [13:0]       buff_addr_q;
    logic [7:0]        buff_dout_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic              mem_rd_q, mem_wr_q;
    logic [7:0]        mem_wdata_q;
    logic              err_q;

    logic [3:0]        req, elig;
    logic              gnt_vld;
    logic [1:0]        gnt_ch, scan_ch;
    logic [31:0]       tot_full;
    logic [32:0]       end_blk;

    // Drive base in the top two bits; block offset wraps inside the drive's quarter.
    function automatic logic [MEM_AW-1:0] addr_of(input logic [13:0] i);
        logic [OffW-1:0] off;
        off = OffW'((64'(lba_q) << ShAmt) + 64'(i));
        return {sel_q, off};
    endfunction

    // Round-robin search from last_q+1; arm bit blocks re-serving a request still held high.
    always_comb begin
        req     = sd.sd_rd | sd.sd_wr;
        elig    = arm_q & req;
        gnt_vld = 1'b0;
        gnt_ch  = 2'd0;
        scan_ch = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_ch = last_q + 2'(k);
            if (!gnt_vld && elig[scan_ch]) begin
                gnt_vld = 1'b1;
                gnt_ch  = scan_ch;
            end
        end
        arm_d = arm_q | ~req;
        if (state_q == StDone) begin
            arm_d[sel_q] = 1'b0;
        end
    end

    always_comb begin
        tot_full   = (32'(cnt_q) + 32'd1) << ShAmt;
        tot_last_d = (tot_full > MaxBytes) ? 14'h3fff : 14'(tot_full - 32'd1);
        end_blk    = {1'b0, lba_q} + 33'(cnt_q);
        bad_d      = end_blk >= 33'(img_blocks_i[sel_q]);
`ifdef SD_BLK_SERVER_WP_EN
        if (op_wr_q && img_wp_i[sel_q]) begin
            bad_d = 1'b1;
        end
`endif
        idx_nx     = idx_q + 14'd1;
        last_byte  = (idx_q == tot_last_q);
    end

`ifdef SD_BLK_SERVER_WP_EN
`else
    logic unused_wp;
    assign unused_wp = ^img_wp_i;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            arm_q       <= 4'hf;
            last_q      <= 2'd3;
            sel_q       <= 2'd0;
            op_wr_q     <= 1'b0;
            bad_q       <= 1'b0;
            lba_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            tot_last_q  <= '0;
            ack_q       <= '0;
            buff_wr_q   <= 1'b0;
            buff_addr_q <= '0;
            buff_dout_q <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            arm_q     <= arm_d;
            err_q     <= 1'b0;
            buff_wr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_vld) begin
                        sel_q   <= gnt_ch;
                        op_wr_q <= !sd.sd_rd[gnt_ch];  // read wins when both are high
                        lba_q   <= sd.sd_lba[gnt_ch];
                        cnt_q   <= sd.sd_blk_cnt[gnt_ch];
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    ack_q       <= 4'b0001 << sel_q;
                    idx_q       <= '0;
                    tot_last_q  <= tot_last_d;
                    bad_q       <= bad_d;
                    err_q       <= bad_d;
                    buff_addr_q <= '0;
                    mem_addr_q  <= addr_of(14'd0);
                    if (op_wr_q) begin
                        state_q <= StWrAddr;
                    end else begin
                        mem_rd_q <= !bad_d;
                        state_q  <= StRdMem;
                    end
                end
                StRdMem: begin
                    if (bad_q) begin
                        buff_dout_q <= 8'h00;
                        buff_wr_q   <= 1'b1;
                        state_q     <= StRdPut;
                    end else if (mem_ready_i) begin
                        mem_rd_q    <= 1'b0;
                        buff_dout_q <= mem_rdata_i;
                        buff_wr_q   <= 1'b1;
                        state_q     <= StRdPut;
                    end
                end
                StRdPut: begin
                    idx_q <= idx_nx;
                    if (last_byte) begin
                        state_q <= StDone;
                    end else begin
                        buff_addr_q <= idx_nx;
                        mem_addr_q  <= addr_of(idx_nx);
                        mem_rd_q    <= !bad_q;
                        state_q     <= StRdMem;
                    end
                end
                StWrAddr: begin
                    // Buffer registers sd_buff_addr here; data shows up next cycle.
                    state_q <= StWrGet;
                end
                StWrGet: begin
                    mem_wdata_q <= sd.sd_buff_din[sel_q];
                    if (!bad_q) begin
                        mem_wr_q <= 1'b1;
                        state_q  <= StWrMem;
                    end else begin
                        idx_q <= idx_nx;
                        if (last_byte) begin
                            state_q <= StDone;
                        end else begin
                            buff_addr_q <= idx_nx;
                            mem_addr_q  <= addr_of(idx_nx);
                            state_q     <= StWrAddr;
                        end
                    end
                end
                StWrMem: begin
                    if (mem_ready_i) begin
                        mem_wr_q <= 1'b0;
                        idx_q    <= idx_nx;
                        if (last_byte) begin
                            state_q <= StDone;
                        end else begin
                            buff_addr_q <= idx_nx;
                            mem_addr_q  <= addr_of(idx_nx);
                            state_q     <= StWrAddr;
                        end
                    end
                end
                StDone: begin
                    ack_q   <= '0;
                    last_q  <= sel_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sd.sd_ack       = ack_q;
    assign sd.sd_buff_wr   = buff_wr_q;
    assign sd.sd_buff_addr = buff_addr_q;
    assign sd.sd_buff_dout = buff_dout_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_rd_o        = mem_rd_q;
    assign mem_wr_o        = mem_wr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_sd_blk_server.sv
// tb_sd_blk_server: directed bench for sd_blk_server (BLKSZ=2, MEM_AW=24).
// Backing store returns the low address byte as data; initiator buffers return
// 0xA5 ^ addr[7:0] ^ channel one cycle after sd_buff_addr.
module tb_sd_blk_server;
    logic        CLK;
    logic        RESET_N;
    logic [23:0] img_blocks [4];
    logic [3:0]  img_wp;
    logic [23:0] mem_addr;
    logic        mem_rd, mem_wr, mem_ready, err;
    logic [7:0]  mem_wdata, mem_rdata;

    sd_blk_if sd ();

    sd_blk_server #(.BLKSZ(2), .MEM_AW(24)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .sd           (sd.slave),
        .img_blocks_i (img_blocks),
        .img_wp_i     (img_wp),
        .mem_addr_o   (mem_addr),
        .mem_rd_o     (mem_rd),
        .mem_wr_o     (mem_wr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ready_i  (mem_ready),
        .err_o        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Store model: ready after lat cycles of a held strobe.
    int lat = 1;
    int lat_cnt;
    assign mem_ready = (mem_rd || mem_wr) && (lat_cnt == lat - 1);
    assign mem_rdata = mem_addr[7:0];
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) lat_cnt <= 0;
        else if ((mem_rd || mem_wr) && !mem_ready) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end

    // Initiator buffer model: registered read port.
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            sd.sd_buff_din[i] <= 8'hA5 ^ sd.sd_buff_addr[7:0] ^ 8'(i);
        end
    end

    // Negedge monitor: counts and per-byte scoreboard.
    int   buffwr_cnt, bad_rd, rd_cnt, wr_cnt, bad_mem, err_cnt, dbl_wr, first_addr;
    int   xfer_idx, mem_idx;
    bit   rd_zero;
    logic [3:0] prev_ack = '0;
    logic       prev_bwr = 1'b0;
    always @(negedge CLK) begin
        int ch;
        logic [23:0] ea;
        ch = 0;
        for (int i = 0; i < 4; i++) if (sd.sd_ack[i]) ch = i;
        if (sd.sd_ack != 4'd0 && prev_ack == 4'd0) begin
            xfer_idx = 0;
            mem_idx  = 0;
        end
        prev_ack = sd.sd_ack;
        if (sd.sd_buff_wr) begin
            if (buffwr_cnt == 0) first_addr = int'(sd.sd_buff_addr);
            buffwr_cnt++;
            if (sd.sd_buff_addr != 14'(xfer_idx) ||
                sd.sd_buff_dout != (rd_zero ? 8'h00 : 8'(xfer_idx))) bad_rd++;
            xfer_idx++;
            if (prev_bwr) dbl_wr++;
        end
        prev_bwr = sd.sd_buff_wr;
        if ((mem_rd || mem_wr) && mem_ready) begin
            ea = {2'(ch), 22'((sd.sd_lba[ch] << 9) + 32'(mem_idx))};
            if (mem_addr != ea) bad_mem++;
            if (mem_wr && mem_wdata != (8'hA5 ^ 8'(mem_idx) ^ 8'(ch))) bad_mem++;
            if (mem_rd) rd_cnt++;
            else wr_cnt++;
            mem_idx++;
        end
        if (mem_rd && mem_wr) bad_mem++;
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        buffwr_cnt = 0; bad_rd = 0; rd_cnt = 0; wr_cnt = 0; bad_mem = 0;
        err_cnt = 0; dbl_wr = 0; first_addr = -1;
    endtask

    function automatic logic [63:0] outs_now();
        return {2'b0, sd.sd_ack, sd.sd_buff_wr, sd.sd_buff_addr, sd.sd_buff_dout,
                mem_rd, mem_wr, mem_addr, mem_wdata, err};
    endfunction

    // One-block transfer; request dropped once acked. Timeouts surface as wrong counts.
    task automatic do_xfer(input int ch, input bit is_wr, input logic [31:0] lba,
                           output int lat_cyc, output int hi_cyc, output logic [3:0] ack_seen);
        @(negedge CLK);
        sd.sd_lba[ch]     = lba;
        sd.sd_blk_cnt[ch] = 6'd0;
        if (is_wr) sd.sd_wr[ch] = 1'b1;
        else sd.sd_rd[ch] = 1'b1;
        lat_cyc = 0;
        while (!sd.sd_ack[ch] && lat_cyc < 20) begin
            @(negedge CLK);
            lat_cyc++;
        end
        ack_seen = sd.sd_ack;
        sd.sd_rd[ch] = 1'b0;
        sd.sd_wr[ch] = 1'b0;
        hi_cyc = 0;
        while (sd.sd_ack[ch] && hi_cyc < 20000) begin
            hi_cyc++;
            @(negedge CLK);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lc, hc, n;
        logic [3:0] ak;
        RESET_N = 1'b0;
        sd.sd_rd = '0;
        sd.sd_wr = '0;
        img_wp   = '0;
        for (int i = 0; i < 4; i++) begin
            sd.sd_lba[i] = '0;
            sd.sd_blk_cnt[i] = '0;
            img_blocks[i] = 24'd2880;
        end
        img_blocks[0] = 24'd720;
        clear_counts();
        rd_zero = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outs", outs_now(), 64'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Single read: ch0 lba 2, Lm=1.
        clear_counts();
        lat = 1;
        do_xfer(0, 1'b0, 32'd2, lc, hc, ak);
        check("rd_ack_lat", 64'(lc), 64'd2);
        check("rd_ack_onehot", 64'(ak), 64'h1);
        check("rd_ack_cycles", 64'(hc), 64'd1025);
        check("rd_strobes", 64'(buffwr_cnt), 64'd512);
        check("rd_bytes", 64'(bad_rd), 64'd0);
        check("rd_memrd", 64'(rd_cnt), 64'd512);
        check("rd_memaddr", 64'(bad_mem), 64'd0);
        check("rd_err", 64'(err_cnt), 64'd0);
        check("rd_dbl_wr", 64'(dbl_wr), 64'd0);

        // Single write: ch2 lba 0, Lm=3 -> 5 cycles per byte.
        clear_counts();
        lat = 3;
        do_xfer(2, 1'b1, 32'd0, lc, hc, ak);
        check("wr_ack_lat", 64'(lc), 64'd2);
        check("wr_ack_onehot", 64'(ak), 64'h4);
        check("wr_ack_cycles", 64'(hc), 64'd2561);
        check("wr_memwr", 64'(wr_cnt), 64'd512);
        check("wr_addr_data", 64'(bad_mem), 64'd0);
        check("wr_memrd", 64'(rd_cnt), 64'd0);
        check("wr_err", 64'(err_cnt), 64'd0);

        // Arbitration from reset (last=3): ch1 then ch3; held ch1 not re-served.
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        clear_counts();
        lat = 1;
        @(negedge CLK);
        sd.sd_lba[1] = 32'd1;
        sd.sd_lba[3] = 32'd1;
        sd.sd_rd = 4'b1010;
        n = 0;
        while (sd.sd_ack == 4'd0 && n < 20) begin @(negedge CLK); n++; end
        check("arb_first", 64'(sd.sd_ack), 64'h2);
        n = 0;
        while (sd.sd_ack != 4'd0 && n < 3000) begin @(negedge CLK); n++; end
        n = 0;
        while (sd.sd_ack == 4'd0 && n < 20) begin @(negedge CLK); n++; end
        check("arb_second", 64'(sd.sd_ack), 64'h8);
        sd.sd_rd[3] = 1'b0;
        n = 0;
        while (sd.sd_ack != 4'd0 && n < 3000) begin @(negedge CLK); n++; end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (sd.sd_ack != 4'd0) n++;
        end
        check("arb_no_reserve", 64'(n), 64'd0);
        sd.sd_rd[1] = 1'b0;
        do_xfer(1, 1'b0, 32'd1, lc, hc, ak);
        check("arb_rearm_lat", 64'(lc), 64'd2);
        check("arb_rearm_ch", 64'(ak), 64'h2);
        check("arb_strobes", 64'(buffwr_cnt), 64'd1536);
        check("arb_bytes", 64'(bad_rd + bad_mem), 64'd0);

        // Out of range: ch0 lba 720 with 720-block image.
        clear_counts();
        rd_zero = 1'b1;
        do_xfer(0, 1'b0, 32'd720, lc, hc, ak);
        check("oor_err", 64'(err_cnt), 64'd1);
        check("oor_memrd", 64'(rd_cnt), 64'd0);
        check("oor_strobes", 64'(buffwr_cnt), 64'd512);
        check("oor_zero_bytes", 64'(bad_rd), 64'd0);
        rd_zero = 1'b0;

        // Write to protected drive 1.
        clear_counts();
        img_wp[1] = 1'b1;
        do_xfer(1, 1'b1, 32'd0, lc, hc, ak);
        check("wp_ack_onehot", 64'(ak), 64'h2);
        check("wp_ack_done", 64'(sd.sd_ack), 64'h0);
`ifdef SD_BLK_SERVER_WP_EN
        check("wp_err", 64'(err_cnt), 64'd1);
        check("wp_memwr", 64'(wr_cnt), 64'd0);
`else
        check("wp_err", 64'(err_cnt), 64'd0);
        check("wp_memwr", 64'(wr_cnt), 64'd512);
`endif
        img_wp[1] = 1'b0;

        // Reset in the middle of a read, then a fresh read restarts at addr 0.
        clear_counts();
        @(negedge CLK);
        sd.sd_lba[0] = 32'd2;
        sd.sd_rd[0] = 1'b1;
        n = 0;
        while (buffwr_cnt < 100 && n < 1000) begin @(negedge CLK); n++; end
        check("mid_reached", 64'(buffwr_cnt), 64'd100);
        #1 RESET_N = 1'b0;
        #1 check("mid_reset_outs", outs_now(), 64'd0);
        @(negedge CLK);
        sd.sd_rd[0] = 1'b0;
        RESET_N = 1'b1;
        clear_counts();
        repeat (2) @(negedge CLK);
        do_xfer(0, 1'b0, 32'd2, lc, hc, ak);
        check("restart_lat", 64'(lc), 64'd2);
        check("restart_first_addr", 64'(first_addr), 64'd0);
        check("restart_strobes", 64'(buffwr_cnt), 64'd512);
        check("restart_bytes", 64'(bad_rd + bad_mem), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_blk_server.md
# sd_blk_server

Responder side of the MiSTer SD block-level interface: serves `sd_rd`/`sd_wr` block requests from up to four initiator channels (e.g. the floppy controller's per-drive ports) out of a byte-wide backing store (SDRAM ramdisk or simulation memory). It arbitrates between channels, drives `sd_ack`, and streams bytes through the initiator's dual-port sector buffer via `sd_buff_addr`/`sd_buff_dout`/`sd_buff_wr`, reading back through `sd_buff_din`. It replaces the HPS for standalone and simulation builds.

## Interface
- `BLKSZ`, 2 — block size is 1<<(BLKSZ+7) bytes; the default gives 512-byte blocks.
- `MEM_AW`, 24 — backing store byte-address width; each drive owns 1/4 of the space at base `drive<<(MEM_AW-2)`.
- `CLK` in 1 — system clock; all logic on posedge.
- `RESET_N` in 1 — reset, asynchronous, active-low.
- `sd_lba[4]` in 32 — per-channel block address, sampled at grant.
- `sd_blk_cnt[4]` in 6 — per-channel block count minus 1, sampled at grant.
- `sd_rd` in 4 — read request per channel; level, held until `sd_ack`.
- `sd_wr` in 4 — write request per channel; level, held until `sd_ack`.
- `sd_ack` out 4 — one-hot, high for the whole transfer of the granted channel.
- `sd_buff_addr` out 14 — byte index within the transfer; initiators with 9-bit buffers use bits [8:0].
- `sd_buff_dout` out 8 — read data to the initiator buffer.
- `sd_buff_din[4]` in 8 — initiator buffer output; valid 1 cycle after `sd_buff_addr` changes.
- `sd_buff_wr` out 1 — 1-cycle strobe that writes `sd_buff_dout` at `sd_buff_addr`.
- `img_blocks[4]` in 24 — per-drive image size in blocks.
- `img_wp` in 4 — per-drive write protect.
- `mem_addr` out MEM_AW — backing store address.
- `mem_rd` / `mem_wr` out 1 — request strobes, held until `mem_ready`.
- `mem_wdata` out 8; `mem_rdata` in 8; `mem_ready` in 1 — the access completes in the cycle `mem_ready` is high.
- `err` out 1 — 1-cycle pulse on an out-of-range or write-protected request.

## Operation
- States: IDLE, GRANT, RD_MEM, RD_PUT, WR_ADDR, WR_GET, WR_MEM, DONE.
- Arm bits `arm[3:0]`: reset to 1111. A channel is eligible when `arm[i] & (sd_rd[i]|sd_wr[i])`. DONE clears `arm[sel]`. `arm[i]` sets again in any cycle where `sd_rd[i]|sd_wr[i]` is 0, so a held request is never served twice.
- IDLE: round-robin grant. The search starts at `last+1` mod 4, where `last` resets to 3. If `sd_rd` and `sd_wr` are both high on one channel, read wins. The block latches sel, op, lba, cnt, and moves to GRANT.
- GRANT: assert `sd_ack[sel]` (held until DONE exits), set `idx=0`, `total=(cnt+1)<<(BLKSZ+7)` saturated to 16384.
- Range check at GRANT: `lba+cnt >= img_blocks[sel]`, computed in 33 bits, marks the request bad and pulses `err`.
- Address: `mem_addr = (sel<<(MEM_AW-2)) + ((lba<<(BLKSZ+7)) + idx)` truncated to MEM_AW-2 bits.
- Read path: RD_MEM issues `mem_rd` and waits for `mem_ready`. A bad request skips the memory access and uses data 0x00. RD_PUT drives `sd_buff_addr=idx`, `sd_buff_dout=data`, `sd_buff_wr=1` for 1 cycle, then `idx++`. It goes to DONE when `idx==total-1`, otherwise back to RD_MEM.
- Write path: WR_ADDR drives `sd_buff_addr=idx`. WR_GET captures `sd_buff_din[sel]`. WR_MEM issues `mem_wr` with `mem_wdata` and waits for `mem_ready`, then `idx++` and loops or goes to DONE. A bad request skips WR_MEM; the bytes are still read and discarded.
- DONE: drop `sd_ack`, clear `arm[sel]`, set `last=sel`, return to IDLE.
- Requests that drop before they are granted are ignored. Requests that drop mid-transfer do not abort the transfer.

## Timing
- Reset values: `sd_ack=0`, `sd_buff_wr=0`, `sd_buff_addr=0`, `sd_buff_dout=0`, `mem_rd=0`, `mem_wr=0`, `mem_addr=0`, `mem_wdata=0`, `err=0`, state IDLE. An asynchronous reset mid-transfer abandons it immediately; `mem_*` strobes drop with no completion.
- Request to `sd_ack` rising: 2 cycles (IDLE grant, then GRANT).
- Read, per byte: 1 + Lm cycles, where Lm is cycles until `mem_ready` (minimum 1). A 512-byte read with Lm=1 takes 1024 cycles plus 3 overhead.
- Write, per byte: 2 + Lm cycles.
- `sd_buff_addr` is stable for the whole byte period. `sd_buff_wr` is never high in two consecutive cycles.
- After DONE, the earliest new grant is the next cycle, and goes to a different channel if one is eligible.

## Configuration
- `SD_BLK_SERVER_WP_EN` defined: a `sd_wr` to a drive with `img_wp[sel]=1` is treated as bad. The block pulses `err`, transfers and discards the bytes, issues no `mem_wr`, and still acks normally.
- `SD_BLK_SERVER_WP_EN` undefined: `img_wp` is ignored, and only out-of-range requests raise `err`.

## Test plan
- **Single read:** ch0 `sd_rd`, lba=2, cnt=0, memory byte at 0x400+k holds k&0xFF, Lm=1 -> `sd_ack[0]` rises 2 cycles after the request, 512 `sd_buff_wr` strobes with addr k and data k&0xFF, `sd_ack` falls after the last strobe, `err=0`.
- **Single write:** ch2 `sd_wr`, lba=0, buffer holds 0xA5, Lm=3 -> 512 `mem_wr` at 0x800000..0x8001FF (MEM_AW=24) with data 0xA5, 5 cycles per byte.
- **Arbitration:** `sd_rd` on ch1 and ch3 in the same cycle with last=3 -> ch1 served first, then ch3. Holding ch1 `sd_rd` high afterwards produces no second transfer until it drops for at least 1 cycle.
- **Out of range:** `img_blocks[0]=720`, lba=720 read -> `err` pulse, 512 bytes of 0x00, no `mem_rd`.
- **Write protect:** with `SD_BLK_SERVER_WP_EN`, `img_wp[1]=1`, ch1 write -> `err`, zero `mem_wr`, `sd_ack` cycle completes normally.
- **Reset mid-read:** assert RESET_N low at byte 100 -> all outputs 0 asynchronously. After release, a fresh ch0 request restarts at addr 0.
